// File: rtl/sd_dat_tx.sv
// rtl/sd_dat_tx.sv - SD DAT0 1-bit block writer: FIFO words to start/data/CRC16/end, CRC token and busy handling
module sd_dat_tx #(
    parameter int STATUS_TIMEOUT = 64,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 start_transfer,
    input  logic                 stop,
    input  logic [11:0]          block_size,
    input  logic [CNT_WIDTH-1:0] block_count,
    input  logic [31:0]          data_from_fifo,
    input  logic                 fifo_empty,
    input  logic                 dat_in,
    output logic                 fifo_read,
    output logic                 dat_out,
    output logic                 dat_oe,
    output logic                 sd_clk_en,
    output logic                 active,
    output logic                 transfer_done,
    output logic                 crc_status_error,
    output logic                 token_timeout_error,
    output logic                 size_error
);

    localparam int TMO_W = $clog2(STATUS_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(STATUS_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_LOAD, S_START, S_DATA, S_WAIT_FIFO, S_RELOAD,
        S_CRC, S_END, S_STATUS, S_TOKEN, S_BUSY
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] blocks_q, blocks_d;
    logic [11:0]          nwords_q, nwords_d;
    logic [11:0]          words_q, words_d;
    logic [31:0]          shift_q, shift_d;
    logic [4:0]           bit_cnt_q, bit_cnt_d;
    logic [15:0]          crc_q, crc_d;
    logic [3:0]           crc_cnt_q, crc_cnt_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic [2:0]           tok_q, tok_d;
    logic [1:0]           tok_cnt_q, tok_cnt_d;
    logic                 pend_q, pend_d;
    logic                 last_bit_q, last_bit_d;
    logic                 done_q, done_d;
    logic                 crc_err_q, crc_err_d;
    logic                 tmo_err_q, tmo_err_d;
    logic                 size_err_q, size_err_d;

    function automatic logic [15:0] crc_next(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= S_IDLE;
            blocks_q   <= '0;
            nwords_q   <= '0;
            words_q    <= '0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            crc_q      <= '0;
            crc_cnt_q  <= '0;
            tmo_q      <= '0;
            tok_q      <= '0;
            tok_cnt_q  <= '0;
            pend_q     <= 1'b0;
            last_bit_q <= 1'b1;
            done_q     <= 1'b0;
            crc_err_q  <= 1'b0;
            tmo_err_q  <= 1'b0;
            size_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            blocks_q   <= blocks_d;
            nwords_q   <= nwords_d;
            words_q    <= words_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            crc_q      <= crc_d;
            crc_cnt_q  <= crc_cnt_d;
            tmo_q      <= tmo_d;
            tok_q      <= tok_d;
            tok_cnt_q  <= tok_cnt_d;
            pend_q     <= pend_d;
            last_bit_q <= last_bit_d;
            done_q     <= done_d;
            crc_err_q  <= crc_err_d;
            tmo_err_q  <= tmo_err_d;
            size_err_q <= size_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        blocks_d   = blocks_q;
        nwords_d   = nwords_q;
        words_d    = words_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        crc_d      = crc_q;
        crc_cnt_d  = crc_cnt_q;
        tmo_d      = tmo_q;
        tok_d      = tok_q;
        tok_cnt_d  = tok_cnt_q;
        pend_d     = pend_q;
        last_bit_d = last_bit_q;
        done_d     = 1'b0;
        crc_err_d  = crc_err_q;
        tmo_err_d  = tmo_err_q;
        size_err_d = size_err_q;
        fifo_read  = 1'b0;
        dat_oe     = 1'b0;
        dat_out    = 1'b1;
        sd_clk_en  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_transfer) begin
                    blocks_d   = block_count;
                    nwords_d   = block_size >> 2;
                    words_d    = block_size >> 2;
                    crc_err_d  = 1'b0;
                    tmo_err_d  = 1'b0;
                    size_err_d = 1'b0;
                    if (block_count == '0) begin
                        done_d = 1'b1;
                    end else if (block_size[11:2] == 10'd0) begin
                        size_err_d = 1'b1;
                        done_d     = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (!fifo_empty) begin
                    fifo_read = 1'b1;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                shift_d   = data_from_fifo;
                crc_d     = '0;
                bit_cnt_d = 5'd31;
                words_d   = words_q - 12'd1;
                state_d   = S_START;
            end
            S_START: begin
                dat_oe    = 1'b1;
                dat_out   = 1'b0;
                sd_clk_en = 1'b1;
                pend_d    = 1'b0;
                state_d   = S_DATA;
            end
            S_DATA: begin
                dat_oe     = 1'b1;
                dat_out    = shift_q[31];
                sd_clk_en  = 1'b1;
                crc_d      = crc_next(crc_q, shift_q[31]);
                shift_d    = {shift_q[30:0], 1'b0};
                last_bit_d = shift_q[31];
                bit_cnt_d  = bit_cnt_q - 5'd1;
                // Pop one bit early so the next word is on data_from_fifo exactly at bit 0.
                if (bit_cnt_q == 5'd1 && words_q != '0 && !fifo_empty) begin
                    fifo_read = 1'b1;
                    pend_d    = 1'b1;
                end
                if (bit_cnt_q == 5'd0) begin
                    if (words_q == '0) begin
                        crc_cnt_d = 4'd15;
                        state_d   = S_CRC;
                    end else if (pend_q) begin
                        shift_d   = data_from_fifo;
                        bit_cnt_d = 5'd31;
                        words_d   = words_q - 12'd1;
                        pend_d    = 1'b0;
                    end else begin
                        state_d = S_WAIT_FIFO;
                    end
                end
            end
            S_WAIT_FIFO: begin
                dat_oe  = 1'b1;
                dat_out = last_bit_q;
                if (!fifo_empty) begin
                    fifo_read = 1'b1;
                    state_d   = S_RELOAD;
                end
            end
            S_RELOAD: begin
                dat_oe    = 1'b1;
                dat_out   = last_bit_q;
                shift_d   = data_from_fifo;
                bit_cnt_d = 5'd31;
                words_d   = words_q - 12'd1;
                state_d   = S_DATA;
            end
            S_CRC: begin
                dat_oe    = 1'b1;
                dat_out   = crc_q[15];
                sd_clk_en = 1'b1;
                crc_d     = {crc_q[14:0], 1'b0};
                crc_cnt_d = crc_cnt_q - 4'd1;
                if (crc_cnt_q == 4'd0) begin
                    state_d = S_END;
                end
            end
            S_END: begin
                dat_oe    = 1'b1;
                sd_clk_en = 1'b1;
                tmo_d     = '0;
                state_d   = S_STATUS;
            end
            S_STATUS: begin
                sd_clk_en = 1'b1;
                if (!dat_in) begin
                    tok_cnt_d = 2'd0;
                    state_d   = S_TOKEN;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_err_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_TOKEN: begin
                // Three token bits, then the token end bit, which carries no information.
                sd_clk_en = 1'b1;
                tok_cnt_d = tok_cnt_q + 2'd1;
                if (tok_cnt_q != 2'd3) begin
                    tok_d = {tok_q[1:0], dat_in};
                end else if (tok_q != 3'b010) begin
                    crc_err_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                sd_clk_en = 1'b1;
                if (dat_in) begin
                    blocks_d = blocks_q - CNT_WIDTH'(1);
                    if (blocks_q == CNT_WIDTH'(1) || stop) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        words_d = nwords_q;
                        state_d = S_FETCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign active              = (state_q != S_IDLE);
    assign transfer_done       = done_q;
    assign crc_status_error    = crc_err_q;
    assign token_timeout_error = tmo_err_q;
    assign size_error          = size_err_q;

endmodule

// File: tb/tb_sd_dat_tx.sv
// tb/tb_sd_dat_tx.sv - self-checking bench for sd_dat_tx: FIFO model, card model, bitstream scoreboard
module tb_sd_dat_tx;
    localparam int STATUS_TIMEOUT = 64;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        start_transfer, stop, dat_in;
    logic [11:0] block_size;
    logic [15:0] block_count;
    logic [31:0] data_from_fifo = '0;
    logic        fifo_empty;
    logic        fifo_read, dat_out, dat_oe, sd_clk_en, active, transfer_done;
    logic        crc_status_error, token_timeout_error, size_error;

    sd_dat_tx #(.STATUS_TIMEOUT(STATUS_TIMEOUT), .CNT_WIDTH(16)) dut (
        .CLK(CLK), .RESET(RESET), .start_transfer(start_transfer), .stop(stop),
        .block_size(block_size), .block_count(block_count), .data_from_fifo(data_from_fifo),
        .fifo_empty(fifo_empty), .dat_in(dat_in), .fifo_read(fifo_read), .dat_out(dat_out),
        .dat_oe(dat_oe), .sd_clk_en(sd_clk_en), .active(active), .transfer_done(transfer_done),
        .crc_status_error(crc_status_error), .token_timeout_error(token_timeout_error),
        .size_error(size_error)
    );

    always #5 CLK = ~CLK;

    logic [31:0] mem [0:255];
    logic [7:0]  rd_ptr = 8'd0;
    logic [7:0]  wr_ptr = 8'd0;
    logic [31:0] held_w[$];
    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge CLK) begin
        if (fifo_read && !fifo_empty) begin
            data_from_fifo <= mem[rd_ptr];
            rd_ptr         <= rd_ptr + 8'd1;
        end
    end

    int checks = 0, errors = 0;
    int cyc = 0, rd_cnt = 0, done_cnt = 0, stall_cnt = 0, bits_seen = 0;
    int done_cyc = 0, last_oe_cyc = 0, viol = 0, overlap = 0, word_k = 0;
    bit exp_q[$];
    logic last_bit = 1'b1;

    always @(negedge CLK) begin
        bit e;
        cyc++;
        if (RESET && dat_oe && sd_clk_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL bitstream: extra bit %0b after end of expected stream", dat_out);
            end else begin
                e = exp_q.pop_front();
                if (dat_out !== e) begin
                    errors++;
                    $display("FAIL bitstream bit %0d: got %0b expected %0b", bits_seen, dat_out, e);
                end
            end
            last_bit    = dat_out;
            bits_seen++;
            last_oe_cyc = cyc;
        end else if (RESET && dat_oe && !sd_clk_en) begin
            stall_cnt++;
            checks++;
            if (dat_out !== last_bit) begin
                errors++;
                $display("FAIL stall_hold: got %0b expected %0b", dat_out, last_bit);
            end
        end
        if (fifo_read) rd_cnt++;
        if (fifo_read && fifo_empty) viol++;
        if (transfer_done) begin
            done_cnt++;
            done_cyc = cyc;
            if (active) overlap++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic [15:0] r;
        r = c << 1;
        if (c[15] ^ b) r = r ^ 16'h1021;
        return r;
    endfunction

    task automatic push_word(input logic [31:0] w);
        mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    // Expected bitstream of one block; the first ndirect words go straight into the FIFO.
    task automatic push_block(input int nw, input logic [31:0] w0, input logic [31:0] w1, input int ndirect);
        logic [15:0] c;
        logic [31:0] w;
        c = 16'h0000;
        exp_q.push_back(1'b0);
        for (int i = 0; i < nw; i++) begin
            w = (word_k == 0) ? w0 : (word_k == 1) ? w1 : $urandom;
            word_k++;
            if (i < ndirect) push_word(w);
            else held_w.push_back(w);
            for (int j = 31; j >= 0; j--) begin
                exp_q.push_back(w[j]);
                c = crc_step(c, w[j]);
            end
        end
        for (int j = 15; j >= 0; j--) exp_q.push_back(c[j]);
        exp_q.push_back(1'b1);
    endtask

    task automatic start_xfer(input int size, input int count);
        @(negedge CLK);
        block_size     = 12'(size);
        block_count    = 16'(count);
        start_transfer = 1'b1;
        @(negedge CLK);
        start_transfer = 1'b0;
    endtask

    task automatic wait_end();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge CLK);
            if (dat_oe) seen = 1'b1;
            else if (seen) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_end: end bit never seen, got none expected one");
    endtask

    task automatic respond(input logic [2:0] tok, input int busy);
        dat_in = 1'b0;
        @(negedge CLK) dat_in = tok[2];
        @(negedge CLK) dat_in = tok[1];
        @(negedge CLK) dat_in = tok[0];
        @(negedge CLK) dat_in = 1'b1;
        if (tok == 3'b010) begin
            repeat (busy) begin
                @(negedge CLK) dat_in = 1'b0;
            end
            @(negedge CLK) dat_in = 1'b1;
        end
        repeat (2) @(negedge CLK);
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 5000; i++) begin
            if (done_cnt >= target) return;
            @(negedge CLK);
            #1;
        end
        checks++;
        errors++;
        $display("FAIL wait_done: got %0d pulses expected %0d", done_cnt, target);
    endtask

    typedef struct {
        int          size;
        int          count;
        logic [2:0]  tok;
        int          stop_blk;
        bit          resp;
        int          blocks;
        int          reads;
        bit          e_crc;
        bit          e_to;
        bit          e_size;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int rd0, d0, b0, s0, n;
        vecs[0] = '{8,  1, 3'b010, 0, 1'b1, 1, 2, 1'b0, 1'b0, 1'b0, 32'hA5A5A5A5, 32'h0000FFFF};
        vecs[1] = '{4,  2, 3'b010, 0, 1'b1, 2, 2, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001};
        vecs[2] = '{12, 3, 3'b010, 2, 1'b1, 2, 6, 1'b0, 1'b0, 1'b0, 32'h80000000, 32'h7FFFFFFF};
        vecs[3] = '{4,  2, 3'b101, 0, 1'b1, 1, 1, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0};
        vecs[4] = '{8,  1, 3'b010, 0, 1'b0, 1, 2, 1'b0, 1'b1, 1'b0, 32'h01234567, 32'h89ABCDEF};
        vecs[5] = '{16, 0, 3'b010, 0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[6] = '{2,  1, 3'b010, 0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0};
        vecs[7] = '{23, 1, 3'b010, 0, 1'b1, 1, 5, 1'b0, 1'b0, 1'b0, 32'hCAFEF00D, 32'h5A5A0F0F};

        RESET = 1'b0; start_transfer = 1'b0; stop = 1'b0; dat_in = 1'b1;
        block_size = '0; block_count = '0;
        repeat (3) @(negedge CLK);
        chk("reset_dat_out", 32'(dat_out), 32'd1);
        chk("reset_oe_clk_rd", {29'd0, dat_oe, sd_clk_en, fifo_read}, 32'd0);
        chk("reset_active_done", {30'd0, active, transfer_done}, 32'd0);
        chk("reset_errors", {29'd0, crc_status_error, token_timeout_error, size_error}, 32'd0);
        RESET = 1'b1;

        for (int v = 0; v < 8; v++) begin
            rd0 = rd_cnt; d0 = done_cnt; word_k = 0;
            for (int b = 0; b < vecs[v].blocks; b++)
                push_block(vecs[v].size / 4, vecs[v].w0, vecs[v].w1, vecs[v].size / 4);
            start_xfer(vecs[v].size, vecs[v].count);
            chk($sformatf("v%0d_flags_at_start", v),
                {29'd0, crc_status_error, token_timeout_error, size_error}, {31'd0, vecs[v].e_size});
            for (int b = 1; b <= vecs[v].blocks; b++) begin
                if (b == vecs[v].stop_blk) stop = 1'b1;
                if (vecs[v].resp) begin
                    wait_end();
                    respond(vecs[v].tok, 4);
                end
            end
            wait_done(d0 + 1);
            repeat (3) @(negedge CLK);
            #1;
            stop = 1'b0;
            chk($sformatf("v%0d_done_pulses", v), 32'(done_cnt - d0), 32'd1);
            chk($sformatf("v%0d_fifo_reads", v), 32'(rd_cnt - rd0), 32'(vecs[v].reads));
            chk($sformatf("v%0d_crc_status_error", v), 32'(crc_status_error), 32'(vecs[v].e_crc));
            chk($sformatf("v%0d_token_timeout_error", v), 32'(token_timeout_error), 32'(vecs[v].e_to));
            chk($sformatf("v%0d_size_error", v), 32'(size_error), 32'(vecs[v].e_size));
            chk($sformatf("v%0d_bits_left", v), 32'(exp_q.size()), 32'd0);
            chk($sformatf("v%0d_active_idle", v), 32'(active), 32'd0);
            if (vecs[v].e_to)
                chk($sformatf("v%0d_timeout_latency", v), 32'(done_cyc - last_oe_cyc), 32'(STATUS_TIMEOUT + 1));
        end

        // FIFO runs dry after the first word of a 3-word block and refills 5 cycles into the stall.
        rd0 = rd_cnt; d0 = done_cnt; word_k = 0;
        push_block(3, 32'h12345678, 32'h9ABCDEF0, 1);
        start_xfer(12, 1);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            #1;
            if (dat_oe && !sd_clk_en) begin
                n = 1;
                break;
            end
        end
        chk("stall_seen", 32'(n), 32'd1);
        s0 = stall_cnt - 1;
        repeat (5) @(negedge CLK);
        while (held_w.size() > 0) push_word(held_w.pop_front());
        wait_end();
        respond(3'b010, 4);
        wait_done(d0 + 1);
        repeat (2) @(negedge CLK);
        n = stall_cnt - s0;
        checks++;
        if (n < 6 || n > 7) begin
            errors++;
            $display("FAIL stall_cycles: got %0d expected 6 to 7", n);
        end
        chk("stall_fifo_reads", 32'(rd_cnt - rd0), 32'd3);
        chk("stall_bits_left", 32'(exp_q.size()), 32'd0);
        chk("stall_errors", {29'd0, crc_status_error, token_timeout_error, size_error}, 32'd0);

        // Reset in the middle of the data phase abandons the block silently.
        word_k = 0;
        push_block(2, 32'hF0F0F0F0, 32'h0F0F0F0F, 2);
        b0 = bits_seen;
        start_xfer(8, 2);
        for (int i = 0; i < 500; i++) begin
            @(negedge CLK);
            #1;
            if (bits_seen - b0 >= 41) break;
        end
        chk("rst_mid_reached", 32'(bits_seen - b0), 32'd41);
        d0 = done_cnt;
        RESET = 1'b0;
        #1;
        chk("rst_mid_dat_oe", 32'(dat_oe), 32'd0);
        chk("rst_mid_dat_out", 32'(dat_out), 32'd1);
        chk("rst_mid_active", 32'(active), 32'd0);
        chk("rst_mid_clk_en", 32'(sd_clk_en), 32'd0);
        repeat (4) @(negedge CLK);
        #1;
        chk("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
        RESET = 1'b1;
        exp_q.delete();
        wr_ptr = rd_ptr;
        repeat (2) @(negedge CLK);

        chk("fifo_read_while_empty", 32'(viol), 32'd0);
        chk("done_while_active", 32'(overlap), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/sd_dat_tx.md
Name: sd_dat_tx

Overview:
- Consumer end of the DMA-to-FIFO write path.
- When the dma block raises start_transfer, this block pops 32-bit words from the FIFO and serializes each block onto the SD DAT0 line (1-bit mode) as: start bit, data, CRC16, end bit.
- After each block it receives the card's CRC status token and waits out card busy.
- It gates the card clock whenever the FIFO underruns, so a block never contains a gap.

Parameters:
- STATUS_TIMEOUT, 64: clock cycles allowed after the end bit for the CRC-status start bit to appear.
- CNT_WIDTH, 16: width of block_count and of the remaining-block counter.

Ports:
- CLK  in  1  internal clock (one SD bit per enabled cycle).
- RESET  in  1  asynchronous, active-low reset.
- start_transfer  in  1  one-cycle pulse from dma; starts a multi-block write.
- stop  in  1  stop-at-block-gap request; sampled only at block boundaries.
- block_size  in  12  bytes per block; bits [1:0] are ignored (words = block_size[11:2]).
- block_count  in  CNT_WIDTH  number of blocks; latched on start_transfer.
- data_from_fifo  in  32  FIFO read data; valid the cycle after fifo_read.
- fifo_empty  in  1  FIFO empty flag.
- dat_in  in  1  DAT0 input from the card (CRC token, busy).
- fifo_read  out  1  one-cycle pop strobe.
- dat_out  out  1  serial data to DAT0.
- dat_oe  out  1  DAT0 output enable.
- sd_clk_en  out  1  card clock enable; 0 stalls the card.
- active  out  1  high from the start_transfer capture until the transfer ends.
- transfer_done  out  1  one-cycle pulse at the end of the transfer, whether it completed or ended on an error.
- crc_status_error  out  1  sticky; the card returned a token other than 010.
- token_timeout_error  out  1  sticky; no token start bit within STATUS_TIMEOUT cycles.
- size_error  out  1  sticky; block_size[11:2]==0 at start.

Behaviour:
- Reset: all outputs 0, except dat_out=1. State is IDLE, counters and CRC cleared.
- Error flags: sticky; all are cleared on start_transfer.
- Bit order: each word is sent bit 31 first. CRC is CCITT x^16+x^12+x^5+1, init 0x0000, computed over data bits only, sent MSB first.
- IDLE:
  - start_transfer latches block_count and the word count, and clears errors.
  - block_count==0: pulse transfer_done next cycle, no traffic, stay IDLE.
  - size_error condition: set size_error, pulse transfer_done, stay IDLE.
  - Otherwise go to FETCH. start_transfer outside IDLE is ignored.
- FETCH: sd_clk_en=0, dat_oe=0. Assert fifo_read for one cycle when !fifo_empty, then go to LOAD.
- LOAD: capture data_from_fifo into the shift register, clear CRC, go to START.
- START (1 cycle): dat_oe=1, dat_out=0, sd_clk_en=1.
- DATA:
  - One bit per cycle; the bit counter counts 31 down to 0.
  - At bit count 1, if words remain and !fifo_empty, assert fifo_read.
  - At bit count 0 the next word is loaded, and its bit 31 follows with no bubble.
  - If the FIFO was empty at bit count 1 and words remain, go to WAIT_FIFO after bit 0.
  - After the last word's bit 0, go to CRC.
- WAIT_FIFO:
  - sd_clk_en=0; dat_oe and dat_out hold their last values.
  - Pop as soon as !fifo_empty, load the next cycle, resume DATA with sd_clk_en=1.
- CRC: 16 cycles, then END.
- END: dat_out=1 for 1 cycle, then dat_oe=0 and go to STATUS.
- STATUS:
  - Wait for dat_in==0 (token start).
  - If the timeout counter reaches STATUS_TIMEOUT, set token_timeout_error, pulse transfer_done, go to IDLE.
  - Otherwise shift in 3 token bits, then 1 end bit.
  - Token!=3'b010: set crc_status_error, pulse transfer_done, go to IDLE.
  - Token 010: go to BUSY.
- BUSY:
  - Stay while dat_in==0.
  - On dat_in==1, decrement the remaining-block count.
  - If the count is 0 or stop==1: pulse transfer_done, go to IDLE.
  - Otherwise go to FETCH with the word count reloaded.
- sd_clk_en=1 in START, DATA, CRC, END, STATUS and BUSY; 0 elsewhere.
- active=1 in every state except IDLE; it falls in the same cycle transfer_done pulses.
- fifo_read is never asserted while fifo_empty=1.
- RESET asserted mid-operation: immediate return to the reset values. The partially sent block is abandoned and transfer_done is not pulsed.

Test Plan:
- block_size=8, block_count=1, FIFO holds 0xA5A5A5A5 and 0x0000FFFF, card returns token 010 then 4 busy cycles -> DAT0 carries 0, 64 data bits MSB first, the CRC16 of those data bits, then 1. Exactly 2 fifo_read pulses, no stall, one transfer_done, no error flags.
- FIFO empties after the first word of a 3-word block, refilled 5 cycles later -> sd_clk_en low for those cycles, dat_out held, the bitstream otherwise identical to the no-stall case.
- block_count=3 with stop raised during block 2 -> exactly 2 blocks sent, transfer_done after the second block's busy phase ends.
- Card returns token 101 -> crc_status_error=1, transfer_done pulses, state IDLE; next start_transfer clears the flag.
- dat_in held high after the end bit -> token_timeout_error set 64 cycles after END, transfer_done pulses; block_size=2 at start -> size_error set, no fifo_read.
- RESET asserted at data bit 40 -> dat_oe=0, dat_out=1, active=0 immediately; no transfer_done.
